// File: rtl/balance_update.sv
// balance_update: read-modify-write engine committing deposits and withdrawals to the balance RAM.
// Define WITHDRAW_LIMIT_EN to reject withdrawals larger than WD_LIMIT with status LIMIT.
module balance_update #(
  parameter int NUM_ACCOUNTS = 5,
  parameter int ID_W         = 4,
  parameter int BAL_W        = 10,
  parameter int AMT_W        = 10,
  parameter int WD_LIMIT     = 500
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             op_deposit_i,
  input  logic [ID_W-1:0]  id_i,
  input  logic [AMT_W-1:0] amount_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       status_o,
  output logic [BAL_W-1:0] new_balance_o,
  output logic [ID_W-1:0]  ram_addr_o,
  output logic             ram_rd_en_o,
  input  logic [BAL_W-1:0] ram_rdata_i,
  output logic             ram_we_o,
  output logic [BAL_W-1:0] ram_wdata_o
);

  localparam logic [2:0] ST_OK     = 3'd0;
  localparam logic [2:0] ST_BAD_ID = 3'd1;
  localparam logic [2:0] ST_NSF    = 3'd2;
  localparam logic [2:0] ST_OVF    = 3'd3;
  localparam logic [2:0] ST_LIMIT  = 3'd4;

  localparam logic [ID_W:0]  NUM_ACC_V  = (ID_W+1)'(NUM_ACCOUNTS);
  localparam logic [AMT_W:0] WD_LIMIT_V = (AMT_W+1)'(WD_LIMIT);

`ifdef WITHDRAW_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CALC,
    S_WR,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  id_q;
  logic [AMT_W-1:0] amt_q;
  logic             dep_q;
  logic [BAL_W-1:0] bal_q;
  logic [BAL_W-1:0] res_q;
  logic [2:0]       calc_st_q;
  logic [2:0]       status_q;
  logic [BAL_W-1:0] nb_q;

  logic             bad_id;
  logic             over_limit;
  logic [BAL_W-1:0] amt_ext;
  logic [BAL_W:0]   sum;
  logic [BAL_W-1:0] res_d;
  logic [2:0]       calc_st_d;

  assign bad_id     = ({1'b0, id_i} >= NUM_ACC_V);
  assign amt_ext    = BAL_W'(amt_q);
  assign sum        = {1'b0, ram_rdata_i} + {1'b0, amt_ext};
  assign over_limit = LIMIT_EN && ({1'b0, amt_q} > WD_LIMIT_V);

  // Result is evaluated from the RAM word while it is on ram_rdata_i (CALC cycle).
  always_comb begin
    calc_st_d = ST_OK;
    res_d     = ram_rdata_i;
    if (dep_q) begin
      if (sum[BAL_W]) begin
        calc_st_d = ST_OVF;
      end else begin
        res_d = sum[BAL_W-1:0];
      end
    end else if (over_limit) begin
      calc_st_d = ST_LIMIT;
    end else if (amt_ext > ram_rdata_i) begin
      calc_st_d = ST_NSF;
    end else begin
      res_d = ram_rdata_i - amt_ext;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = bad_id ? S_DONE : S_RD;
      S_RD:    state_d = S_CALC;
      S_CALC:  state_d = S_WR;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      amt_q     <= '0;
      dep_q     <= 1'b0;
      bal_q     <= '0;
      res_q     <= '0;
      calc_st_q <= ST_OK;
      status_q  <= ST_OK;
      nb_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            id_q  <= id_i;
            amt_q <= amount_i;
            dep_q <= op_deposit_i;
            // No RAM access for an invalid account, so there is no balance to report.
            if (bad_id) begin
              status_q <= ST_BAD_ID;
              nb_q     <= '0;
            end
          end
        end
        S_CALC: begin
          bal_q     <= ram_rdata_i;
          res_q     <= res_d;
          calc_st_q <= calc_st_d;
        end
        S_WR: begin
          status_q <= calc_st_q;
          nb_q     <= (calc_st_q == ST_OK) ? res_q : bal_q;
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign status_o      = status_q;
  assign new_balance_o = nb_q;
  assign ram_rd_en_o   = (state_q == S_RD);
  assign ram_we_o      = (state_q == S_WR) && (calc_st_q == ST_OK);
  assign ram_addr_o    = ((state_q == S_RD) || (state_q == S_WR)) ? id_q : '0;
  assign ram_wdata_o   = ram_we_o ? res_q : '0;

endmodule

// File: tb/tb_balance_update.sv
// Bench for balance_update: behavioural balance RAM, reference model and expectation queue.
// Honours WITHDRAW_LIMIT_EN the same way as the design.
module tb_balance_update;

`ifdef WITHDRAW_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  typedef struct {
    logic [2:0] st;
    logic [9:0] nb;
    bit         chk_nb;
    bit         wr;
    logic [9:0] wdata;
  } exp_t;

  logic       clk, reset, start, op_dep;
  logic [3:0] id;
  logic [9:0] amount;
  logic       busy, done;
  logic [2:0] status;
  logic [9:0] new_bal;
  logic [3:0] ram_addr;
  logic       ram_rd_en, ram_we;
  logic [9:0] ram_rdata, ram_wdata;

  logic [9:0] mem [16];
  logic       pl_en;
  logic [3:0] pl_addr;
  logic [9:0] pl_data;
  int         exp_mem [16];
  exp_t       sb [$];

  int n_tests, n_fail;
  int m_lat, m_rd_at, m_we_at, m_rd_n, m_we_n, m_busy_n, m_done_n;
  bit m_overlap;
  logic [9:0] m_wdata, m_nb;
  logic [3:0] m_waddr;
  logic [2:0] m_st;
  int w_done, w_we, w_rd, w_busy;

  balance_update dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .op_deposit_i(op_dep),
    .id_i(id), .amount_i(amount), .busy_o(busy), .done_o(done),
    .status_o(status), .new_balance_o(new_bal), .ram_addr_o(ram_addr),
    .ram_rd_en_o(ram_rd_en), .ram_rdata_i(ram_rdata), .ram_we_o(ram_we),
    .ram_wdata_o(ram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
  end

  task automatic preload(input int a, input int d);
    pl_en = 1'b1; pl_addr = a[3:0]; pl_data = d[9:0]; exp_mem[a] = d;
    @(posedge clk); #1; pl_en = 1'b0;
  endtask

  task automatic predict(input bit dep, input int aid, input int amt, output exp_t e);
    int bal, sum;
    e.st = 3'd0; e.nb = 10'd0; e.chk_nb = 1'b1; e.wr = 1'b0; e.wdata = 10'd0;
    if (aid >= 5) begin
      e.st = 3'd1; e.chk_nb = 1'b0;
    end else begin
      bal = exp_mem[aid];
      if (dep) begin
        sum = bal + amt;
        if (sum > 1023) begin e.st = 3'd3; e.nb = 10'(bal); end
        else begin e.nb = 10'(sum); e.wr = 1'b1; end
      end else if (LIM && amt > 500) begin
        e.st = 3'd4; e.nb = 10'(bal);
      end else if (amt > bal) begin
        e.st = 3'd2; e.nb = 10'(bal);
      end else begin
        e.nb = 10'(bal - amt); e.wr = 1'b1;
      end
      if (e.wr) begin e.wdata = e.nb; exp_mem[aid] = int'(e.nb); end
    end
  endtask

  // Entered and left one time unit after a rising edge; start is sampled on the next edge.
  task automatic issue(input bit dep, input int aid, input int amt, input bit push);
    exp_t e;
    if (push) begin predict(dep, aid, amt, e); sb.push_back(e); end
    op_dep = dep; id = aid[3:0]; amount = amt[9:0]; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic measure();
    m_lat = -1; m_rd_at = -1; m_we_at = -1; m_rd_n = 0; m_we_n = 0; m_busy_n = 0;
    m_done_n = 0; m_overlap = 1'b0; m_wdata = 10'd0; m_waddr = 4'd0; m_st = 3'd7; m_nb = 10'd0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (ram_rd_en) begin m_rd_n++; if (m_rd_at < 0) m_rd_at = c; end
      if (ram_we) begin m_we_n++; if (m_we_at < 0) m_we_at = c; m_wdata = ram_wdata; m_waddr = ram_addr; end
      if (ram_rd_en && ram_we) m_overlap = 1'b1;
      if (busy) m_busy_n++;
      if (done) begin m_done_n++; m_lat = c; m_st = status; m_nb = new_bal; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_watch(input int n);
    w_done = 0; w_we = 0; w_rd = 0; w_busy = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) w_done++;
      if (ram_we) w_we++;
      if (ram_rd_en) w_rd++;
      if (busy) w_busy++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, ram_rd_en, ram_we, status, new_bal, ram_addr, ram_wdata} !== 31'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {busy, done, ram_rd_en, ram_we, status, new_bal, ram_addr, ram_wdata});
    end
    $display("[TB] reset: outputs=%h", {busy, done, ram_rd_en, ram_we, status, new_bal, ram_addr, ram_wdata});
    @(posedge clk); #1; reset = 1'b0;
    for (int a = 0; a < 16; a++) preload(a, 0);
  endtask

  task automatic test_deposit();
    exp_t e;
    preload(2, 100);
    issue(1'b1, 2, 25, 1'b1);
    measure();
    e = sb.pop_front();
    $display("[TB] deposit id=2 amt=25: status=%0d new_balance=%0d lat=%0d", m_st, m_nb, m_lat);
    n_tests++; if (m_lat !== 4) begin n_fail++; $display("FAIL dep_latency: got %0d expected 4", m_lat); end
    n_tests++; if (m_rd_at !== 1 || m_rd_n !== 1) begin n_fail++; $display("FAIL dep_rd_timing: got at=%0d n=%0d expected at=1 n=1", m_rd_at, m_rd_n); end
    n_tests++; if (m_we_at !== 3 || m_we_n !== 1) begin n_fail++; $display("FAIL dep_we_timing: got at=%0d n=%0d expected at=3 n=1", m_we_at, m_we_n); end
    n_tests++; if (m_wdata !== e.wdata || m_waddr !== 4'd2) begin n_fail++; $display("FAIL dep_wdata: got %0d@%0d expected %0d@2", m_wdata, m_waddr, e.wdata); end
    n_tests++; if (m_st !== e.st) begin n_fail++; $display("FAIL dep_status: got %0d expected %0d", m_st, e.st); end
    n_tests++; if (m_nb !== e.nb) begin n_fail++; $display("FAIL dep_new_balance: got %0d expected %0d", m_nb, e.nb); end
    n_tests++; if (m_busy_n !== 4 || m_overlap) begin n_fail++; $display("FAIL dep_busy: got busy=%0d overlap=%0d expected 4/0", m_busy_n, m_overlap); end
  endtask

  task automatic test_withdraw();
    exp_t e;
    preload(1, 40);
    issue(1'b0, 1, 41, 1'b1);
    measure();
    e = sb.pop_front();
    $display("[TB] withdraw id=1 amt=41: status=%0d new_balance=%0d writes=%0d", m_st, m_nb, m_we_n);
    n_tests++; if (m_st !== e.st) begin n_fail++; $display("FAIL nsf_status: got %0d expected %0d", m_st, e.st); end
    n_tests++; if (m_nb !== e.nb) begin n_fail++; $display("FAIL nsf_new_balance: got %0d expected %0d", m_nb, e.nb); end
    n_tests++; if (m_we_n !== 0) begin n_fail++; $display("FAIL nsf_no_write: got %0d writes expected 0", m_we_n); end
    issue(1'b0, 1, 40, 1'b1);
    measure();
    e = sb.pop_front();
    $display("[TB] withdraw id=1 amt=40: status=%0d new_balance=%0d wdata=%0d", m_st, m_nb, m_wdata);
    n_tests++; if (m_st !== e.st) begin n_fail++; $display("FAIL wd_exact_status: got %0d expected %0d", m_st, e.st); end
    n_tests++; if (m_we_n !== 1 || m_wdata !== e.wdata) begin n_fail++; $display("FAIL wd_exact_write: got n=%0d wdata=%0d expected n=1 wdata=%0d", m_we_n, m_wdata, e.wdata); end
  endtask

  task automatic test_bad_id();
    exp_t e;
    int ids [3];
    ids = '{7, 5, 15};
    foreach (ids[k]) begin
      issue(k[0], ids[k], 10, 1'b1);
      measure();
      e = sb.pop_front();
      $display("[TB] bad id=%0d: status=%0d lat=%0d busy=%0d rd=%0d we=%0d", ids[k], m_st, m_lat, m_busy_n, m_rd_n, m_we_n);
      n_tests++; if (m_st !== e.st) begin n_fail++; $display("FAIL badid_status: got %0d expected %0d", m_st, e.st); end
      n_tests++; if (m_lat !== 1 || m_busy_n !== 1) begin n_fail++; $display("FAIL badid_latency: got lat=%0d busy=%0d expected 1/1", m_lat, m_busy_n); end
      n_tests++; if (m_rd_n !== 0 || m_we_n !== 0) begin n_fail++; $display("FAIL badid_ram: got rd=%0d we=%0d expected 0/0", m_rd_n, m_we_n); end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    int amts [3];
    amts = '{30, 23, 0};
    preload(0, 1000);
    foreach (amts[k]) begin
      issue(1'b1, 0, amts[k], 1'b1);
      measure();
      e = sb.pop_front();
      $display("[TB] deposit id=0 amt=%0d: status=%0d new_balance=%0d writes=%0d wdata=%0d", amts[k], m_st, m_nb, m_we_n, m_wdata);
      n_tests++; if (m_st !== e.st || m_nb !== e.nb) begin n_fail++; $display("FAIL ovf_result: got st=%0d nb=%0d expected st=%0d nb=%0d", m_st, m_nb, e.st, e.nb); end
      n_tests++; if (m_we_n !== int'(e.wr) || (e.wr && m_wdata !== e.wdata)) begin n_fail++; $display("FAIL ovf_write: got n=%0d wdata=%0d expected n=%0d wdata=%0d", m_we_n, m_wdata, e.wr, e.wdata); end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    preload(3, 200);
    issue(1'b1, 3, 5, 1'b1);
    @(posedge clk); #1;
    op_dep = 1'b1; id = 4'd1; amount = 10'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    measure();
    e = sb.pop_front();
    idle_watch(8);
    $display("[TB] start while busy: status=%0d new_balance=%0d waddr=%0d extra_done=%0d", m_st, m_nb, m_waddr, w_done);
    n_tests++; if (m_lat !== 2) begin n_fail++; $display("FAIL busy_latency: got %0d expected 2", m_lat); end
    n_tests++; if (m_nb !== e.nb || m_waddr !== 4'd3 || m_wdata !== e.wdata) begin n_fail++; $display("FAIL busy_result: got nb=%0d addr=%0d wdata=%0d expected nb=%0d addr=3", m_nb, m_waddr, m_wdata, e.nb); end
    n_tests++; if (w_done !== 0 || w_we !== 0 || w_rd !== 0) begin n_fail++; $display("FAIL busy_extra: got done=%0d we=%0d rd=%0d expected 0", w_done, w_we, w_rd); end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    preload(4, 300);
    issue(1'b1, 4, 10, 1'b0);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    $display("[TB] reset in CALC: outputs=%h", {busy, done, ram_rd_en, ram_we, status, new_bal, ram_addr, ram_wdata});
    n_tests++;
    if ({busy, done, ram_rd_en, ram_we, status, new_bal, ram_addr, ram_wdata} !== 31'h0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %h expected 0", {busy, done, ram_rd_en, ram_we, status, new_bal, ram_addr, ram_wdata});
    end
    @(posedge clk); #1; reset = 1'b0;
    idle_watch(6);
    n_tests++; if (w_done !== 0 || w_we !== 0 || w_busy !== 0) begin n_fail++; $display("FAIL abort_quiet: got done=%0d we=%0d busy=%0d expected 0", w_done, w_we, w_busy); end
    issue(1'b1, 4, 10, 1'b1);
    measure();
    e = sb.pop_front();
    $display("[TB] after abort deposit id=4 amt=10: status=%0d new_balance=%0d lat=%0d", m_st, m_nb, m_lat);
    n_tests++; if (m_lat !== 4 || m_st !== e.st || m_nb !== e.nb) begin n_fail++; $display("FAIL abort_recover: got lat=%0d st=%0d nb=%0d expected 4/%0d/%0d", m_lat, m_st, m_nb, e.st, e.nb); end
  endtask

  task automatic test_limit();
    exp_t e;
    preload(3, 900);
    issue(1'b0, 3, 501, 1'b1);
    measure();
    e = sb.pop_front();
    $display("[TB] withdraw id=3 amt=501: status=%0d new_balance=%0d writes=%0d wdata=%0d", m_st, m_nb, m_we_n, m_wdata);
    n_tests++; if (m_st !== e.st || m_nb !== e.nb) begin n_fail++; $display("FAIL limit_result: got st=%0d nb=%0d expected st=%0d nb=%0d", m_st, m_nb, e.st, e.nb); end
    n_tests++; if (m_we_n !== int'(e.wr) || (e.wr && m_wdata !== e.wdata)) begin n_fail++; $display("FAIL limit_write: got n=%0d wdata=%0d expected n=%0d wdata=%0d", m_we_n, m_wdata, e.wr, e.wdata); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit dep;
    int aid, amt;
    for (int t = 0; t < 24; t++) begin
      dep = 1'($urandom_range(0, 1));
      aid = int'($urandom_range(0, 6));
      amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 200));
      issue(dep, aid, amt, 1'b1);
      measure();
      e = sb.pop_front();
      $display("[TB] b2b #%0d dep=%0d id=%0d amt=%0d: status=%0d new_balance=%0d lat=%0d", t, dep, aid, amt, m_st, m_nb, m_lat);
      n_tests++;
      if (m_st !== e.st || (e.chk_nb && m_nb !== e.nb) || m_lat !== ((e.st == 3'd1) ? 1 : 4)) begin
        n_fail++;
        $display("FAIL b2b_result: got st=%0d nb=%0d lat=%0d expected st=%0d nb=%0d", m_st, m_nb, m_lat, e.st, e.nb);
      end
      n_tests++;
      if (m_we_n !== int'(e.wr) || (e.wr && m_wdata !== e.wdata) || m_overlap) begin
        n_fail++;
        $display("FAIL b2b_write: got n=%0d wdata=%0d overlap=%0d expected n=%0d wdata=%0d", m_we_n, m_wdata, m_overlap, e.wr, e.wdata);
      end
    end
    for (int a = 0; a < 5; a++) begin
      n_tests++;
      if (mem[a] !== 10'(exp_mem[a])) begin n_fail++; $display("FAIL ram_final[%0d]: got %0d expected %0d", a, mem[a], exp_mem[a]); end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; op_dep = 1'b0; id = 4'd0; amount = 10'd0;
    pl_en = 1'b0; pl_addr = 4'd0; pl_data = 10'd0;
    test_reset();
    test_deposit();
    test_withdraw();
    test_bad_id();
    test_overflow();
    test_busy_ignore();
    test_reset_abort();
    test_limit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
